// File: rtl/kuznechik_decipher.sv
// kuznechik_decipher
//   Iterative GOST R 34.12-2015 (Kuznyechik) 128-bit block decryptor.
//   Round sequence: X[K10], then nine rounds of L^-1 (one inverse-R byte
//   step per cycle), S^-1 (all 16 bytes in one cycle) and X[Ki], i = 9..1.
//   A block is accepted at edge E0 and its plaintext appears at E163.
//
// Ports
//   clk_i      : clock, all logic on the rising edge
//   reset_i    : synchronous, active-high reset
//   request_i  : start decrypting data_i (ignored while busy_o is high)
//   ack_i      : consumer has taken data_o (only meaningful while valid_o)
//   data_i     : ciphertext, byte 15 = data_i[127:120]
//   busy_o     : core is computing
//   valid_o    : data_o holds a fresh plaintext
//   data_o     : plaintext, held until the next result or reset

module kuznechik_decipher #(
  parameter int NUM_KEYS = 10,
  parameter int L_CYCLES = 16,
  // Round keys, index 0 = K1 ... index 9 = K10. The default is the schedule
  // of the reference key 8899aabb...0123456789abcdef.
  parameter logic [NUM_KEYS-1:0][127:0] ROUND_KEYS = {
    128'h72e9dd7416bcf45b755dbaa88e4a4043,  // K10
    128'hbb44e25378c73123a5f32f73cdb6e517,  // K9
    128'h5a7925017b9fdd3ed72a91a22286f984,  // K8
    128'h51e640757e8745de705727265a0098b1,  // K7
    128'hbd079435165c6432b532e82834da581b,  // K6
    128'h57646468c44a5e28d3e59246f429f1ac,  // K5
    128'h3d4553d8e9cfec6815ebadc40a9ffd04,  // K4
    128'hdb31485315694343228d6aef8cc78c44,  // K3
    128'hfedcba98765432100123456789abcdef,  // K2
    128'h8899aabbccddeeff0011223344556677   // K1
  }
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         request_i,
  input  logic         ack_i,
  input  logic [127:0] data_i,
  output logic         busy_o,
  output logic         valid_o,
  output logic [127:0] data_o
);

  localparam int IDX_W = $clog2(NUM_KEYS);
  localparam int CNT_W = $clog2(L_CYCLES);
  localparam logic [IDX_W-1:0] KEY_LAST = IDX_W'(NUM_KEYS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(L_CYCLES - 1);

  // Forward substitution pi, byte 0 in the most significant position.
  localparam logic [2047:0] PI_FLAT = {
    128'hfceedd11cf6e3116fbc4fada23c5044d,
    128'he977f0db932e99ba1736f1bb14cd5fc1,
    128'hf918655ae25cef21811c3c428b018e4f,
    128'h058402aee36a8fa0060bed987fd4d31f,
    128'heb342c51eac848abf22a68a2fd3acecc,
    128'hb5700e56080c7612bf7213479cb75d87,
    128'h15a19629107b9ac7f391786f9d9eb2b1,
    128'h3275193dff358a7e6d54c680c3bd0d57,
    128'hdff524a93ea843c9d779d6f67c22b903,
    128'he00fecde7a94b0bcdce828504e330a4a,
    128'ha79760731e0062441ab83882649f2641,
    128'had454692275e552f8ca3a57d69d5953b,
    128'h0758b34086ac1df730376be488d9e789,
    128'he11b83494c3ff8fe8d53aa90cad88561,
    128'h207167a42d2b095bcb9b25d0bee56c52,
    128'h59a674d2e6f4b4c0d166afc2394b63b6
  };

  // Inverse table built at elaboration: entry v lives at bits [8v +: 8].
  function automatic logic [2047:0] invert_pi(input logic [2047:0] pi_flat);
    logic [2047:0] inv;
    logic [7:0]    v;
    inv = '0;
    for (int i = 0; i < 256; i++) begin
      v = pi_flat[2047 - 8*i -: 8];
      inv[8*v +: 8] = 8'(i);
    end
    return inv;
  endfunction

  localparam logic [2047:0] SBOX_INV = invert_pi(PI_FLAT);

  // Coefficients of the inverse-R feedback byte for b14..b0 (b15 has
  // coefficient 1). The sequence is symmetric, so index k is byte b_k.
  localparam logic [14:0][7:0] LINV_COEF = {
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1,
    8'd251, 8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148
  };

  // Multiply in GF(2^8) modulo x^8+x^7+x^6+x+1. With a constant k this
  // reduces to a fixed XOR network, equivalent to the shared L_* tables.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] k);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'hc3 : 8'h00);
    end
    return acc;
  endfunction

  typedef enum logic [2:0] {IDLE, KEY, LINV, SINV, FINISH} state_t;

  state_t             r_state, w_state;
  logic [127:0]       r_data,  w_data;
  logic [127:0]       r_out,   w_out;
  logic [IDX_W-1:0]   r_idx,   w_idx;
  logic [CNT_W-1:0]   r_cnt,   w_cnt;
  logic               r_busy,  w_busy;
  logic               r_valid, w_valid;

  logic [127:0]       w_key;
  logic [127:0]       w_linv;
  logic [127:0]       w_sinv;
  logic [7:0]         w_fb;

  assign w_key = ROUND_KEYS[r_idx];

  // One inverse-R step: shift bytes up and append the linear feedback byte.
  always_comb begin
    w_fb = r_data[127:120];
    for (int k = 0; k < 15; k++) begin
      w_fb = w_fb ^ gf_mul(r_data[8*k +: 8], LINV_COEF[k]);
    end
    w_linv = {r_data[119:0], w_fb};
  end

  always_comb begin
    w_sinv = '0;
    for (int k = 0; k < 16; k++) begin
      w_sinv[8*k +: 8] = SBOX_INV[8*r_data[8*k +: 8] +: 8];
    end
  end

  // NOTE: every signal gets its hold value first, so no path through the
  // case below can leave one unassigned and infer a latch.
  always_comb begin
    w_state = r_state;
    w_data  = r_data;
    w_out   = r_out;
    w_idx   = r_idx;
    w_cnt   = r_cnt;
    w_busy  = r_busy;
    w_valid = r_valid;
    case (r_state)
      IDLE: begin
        if (request_i) begin
          w_data  = data_i;
          w_idx   = KEY_LAST;
          w_busy  = 1'b1;
          w_valid = 1'b0;
          w_state = KEY;
        end
      end
      KEY: begin
        w_data = r_data ^ w_key;
        if (r_idx == '0) begin
          w_out   = r_data ^ w_key;
          w_valid = 1'b1;
          w_busy  = 1'b0;
          w_state = FINISH;
        end else begin
          w_idx   = r_idx - 1'b1;
          w_cnt   = '0;
          w_state = LINV;
        end
      end
      LINV: begin
        w_data = w_linv;
        w_cnt  = r_cnt + 1'b1;
        if (r_cnt == CNT_LAST) w_state = SINV;
      end
      SINV: begin
        w_data  = w_sinv;
        w_state = KEY;
      end
      FINISH: begin
        // A request here also acknowledges the current result.
        if (request_i) begin
          w_data  = data_i;
          w_idx   = KEY_LAST;
          w_busy  = 1'b1;
          w_valid = 1'b0;
          w_state = KEY;
        end else if (ack_i) begin
          w_valid = 1'b0;
          w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_out   <= '0;
      r_idx   <= KEY_LAST;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state;
      r_data  <= w_data;
      r_out   <= w_out;
      r_idx   <= w_idx;
      r_cnt   <= w_cnt;
      r_busy  <= w_busy;
      r_valid <= w_valid;
    end
  end

  assign busy_o  = r_busy;
  assign valid_o = r_valid;
  assign data_o  = r_out;

endmodule

// File: tb/tb_kuznechik_decipher.sv
// Self-checking bench for kuznechik_decipher. A behavioural Kuznyechik
// model (own key schedule from the master key, own forward cipher) supplies
// ciphertexts for random round trips; the reference vector is checked
// against its published constants.

module tb_kuznechik_decipher;

  localparam logic [127:0] STD_CT = 128'h7f679d90bebc24305a468d42b9d4edcd;
  localparam logic [127:0] STD_PT = 128'h1122334455667700ffeeddccbbaa9988;
  localparam logic [255:0] MASTER =
    256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
  localparam int LATENCY = 163;

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b1;
  logic         request_i = 1'b0;
  logic         ack_i = 1'b0;
  logic [127:0] data_i = '0;
  logic         busy_o;
  logic         valid_o;
  logic [127:0] data_o;

  int total = 0;
  int bad   = 0;

  kuznechik_decipher dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .request_i (request_i),
    .ack_i     (ack_i),
    .data_i    (data_i),
    .busy_o    (busy_o),
    .valid_o   (valid_o),
    .data_o    (data_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  logic [7:0]   pi_t [256];
  logic [127:0] rk   [10];
  logic [7:0]   lvec [16] = '{8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
                              8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    while (b != 8'h00) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'hc3;
      b  = b >> 1;
    end
    return p;
  endfunction

  // Linear functional l over a15..a0 (a15 is the top byte).
  function automatic logic [7:0] lfun(input logic [127:0] a);
    logic [7:0] x = 8'h00;
    for (int j = 0; j < 16; j++) x = x ^ gmul(a[127 - 8*j -: 8], lvec[j]);
    return x;
  endfunction

  function automatic logic [127:0] lin(input logic [127:0] a);
    for (int r = 0; r < 16; r++) a = {lfun(a), a[127:8]};
    return a;
  endfunction

  function automatic logic [127:0] sub(input logic [127:0] a);
    logic [127:0] o;
    for (int j = 0; j < 16; j++) o[8*j +: 8] = pi_t[a[8*j +: 8]];
    return o;
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
    logic [127:0] x = pt;
    for (int i = 0; i < 9; i++) x = lin(sub(x ^ rk[i]));
    return x ^ rk[9];
  endfunction

  task automatic init_model();
    logic [2047:0] pi_flat;
    logic [127:0]  k1, k2, c, t;
    pi_flat = {
      128'hfceedd11cf6e3116fbc4fada23c5044d, 128'he977f0db932e99ba1736f1bb14cd5fc1,
      128'hf918655ae25cef21811c3c428b018e4f, 128'h058402aee36a8fa0060bed987fd4d31f,
      128'heb342c51eac848abf22a68a2fd3acecc, 128'hb5700e56080c7612bf7213479cb75d87,
      128'h15a19629107b9ac7f391786f9d9eb2b1, 128'h3275193dff358a7e6d54c680c3bd0d57,
      128'hdff524a93ea843c9d779d6f67c22b903, 128'he00fecde7a94b0bcdce828504e330a4a,
      128'ha79760731e0062441ab83882649f2641, 128'had454692275e552f8ca3a57d69d5953b,
      128'h0758b34086ac1df730376be488d9e789, 128'he11b83494c3ff8fe8d53aa90cad88561,
      128'h207167a42d2b095bcb9b25d0bee56c52, 128'h59a674d2e6f4b4c0d166afc2394b63b6};
    for (int i = 0; i < 256; i++) pi_t[i] = pi_flat[2047 - 8*i -: 8];
    // Key schedule: Feistel network with constants C_i = L(Vec128(i)).
    k1 = MASTER[255:128];
    k2 = MASTER[127:0];
    rk[0] = k1;
    rk[1] = k2;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 8; j++) begin
        c  = lin(128'(8*i + j + 1));
        t  = lin(sub(k1 ^ c)) ^ k2;
        k2 = k1;
        k1 = t;
      end
      rk[2*i + 2] = k1;
      rk[2*i + 3] = k2;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [127:0] ct, input logic with_ack);
    @(negedge clk_i);
    request_i = 1'b1;
    data_i    = ct;
    ack_i     = with_ack;
    @(negedge clk_i);
    request_i = 1'b0;
    ack_i     = 1'b0;
    data_i    = ~ct;
  endtask

  // Counts negedges after acceptance until valid_o rises. Optionally
  // injects an all-ones request or a reset at the given count.
  task automatic wait_result(input int inject_at, input int reset_at, output int cycles);
    logic both = 1'b0;
    cycles = 0;
    while (valid_o !== 1'b1 && cycles < 400) begin
      @(negedge clk_i);
      cycles++;
      request_i = 1'b0;
      if (busy_o === 1'b1 && valid_o === 1'b1) both = 1'b1;
      if (cycles == inject_at) begin
        request_i = 1'b1;
        data_i    = '1;
      end
      if (cycles == reset_at) begin
        reset_i = 1'b1;
        break;
      end
    end
    total++;
    if (both !== 1'b0) begin
      bad++;
      $display("FAIL busy_valid_exclusive: got both high, want never");
    end
  endtask

  task automatic do_ack();
    @(negedge clk_i);
    ack_i = 1'b1;
    @(negedge clk_i);
    ack_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(negedge clk_i);
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    total++;
    if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    total++;
    if (data_o !== 128'h0) begin bad++; $display("FAIL reset_data: got %h want 0", data_o); end
    reset_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_standard();
    int cyc;
    send(STD_CT, 1'b0);
    total++;
    if (busy_o !== 1'b1) begin bad++; $display("FAIL std_busy_after_accept: got %b want 1", busy_o); end
    wait_result(-1, -1, cyc);
    total++;
    if (cyc != LATENCY) begin bad++; $display("FAIL std_latency: got %0d want %0d", cyc, LATENCY); end
    total++;
    if (data_o !== STD_PT) begin bad++; $display("FAIL std_data: got %h want %h", data_o, STD_PT); end
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL std_busy_done: got %b want 0", busy_o); end
  endtask

  task automatic test_ack();
    @(negedge clk_i);
    total++;
    if (valid_o !== 1'b1 || data_o !== STD_PT) begin
      bad++; $display("FAIL finish_hold: got valid=%b data=%h want valid=1 data=%h", valid_o, data_o, STD_PT);
    end
    do_ack();
    total++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL ack_flags: got valid=%b busy=%b want 0 0", valid_o, busy_o);
    end
    total++;
    if (data_o !== STD_PT) begin bad++; $display("FAIL ack_data_hold: got %h want %h", data_o, STD_PT); end
    // ack in IDLE must change nothing
    do_ack();
    total++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0 || data_o !== STD_PT) begin
      bad++; $display("FAIL idle_ack: got valid=%b busy=%b data=%h want 0 0 %h", valid_o, busy_o, data_o, STD_PT);
    end
  endtask

  task automatic test_busy_reject();
    int cyc;
    send(STD_CT, 1'b0);
    wait_result(80, -1, cyc);
    total++;
    if (cyc != LATENCY) begin bad++; $display("FAIL reject_latency: got %0d want %0d", cyc, LATENCY); end
    total++;
    if (data_o !== STD_PT) begin bad++; $display("FAIL reject_data: got %h want %h", data_o, STD_PT); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    send(STD_CT, 1'b1);
    total++;
    if (valid_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++; $display("FAIL b2b_restart: got valid=%b busy=%b want 0 1", valid_o, busy_o);
    end
    wait_result(-1, -1, cyc);
    total++;
    if (cyc != LATENCY) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", cyc, LATENCY); end
    total++;
    if (data_o !== STD_PT) begin bad++; $display("FAIL b2b_data: got %h want %h", data_o, STD_PT); end
    do_ack();
  endtask

  task automatic test_reset_mid();
    int cyc;
    send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    wait_result(-1, 50, cyc);
    @(negedge clk_i);
    reset_i = 1'b0;
    total++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0 || data_o !== 128'h0) begin
      bad++; $display("FAIL mid_reset: got busy=%b valid=%b data=%h want 0 0 0", busy_o, valid_o, data_o);
    end
    send(STD_CT, 1'b0);
    wait_result(-1, -1, cyc);
    total++;
    if (cyc != LATENCY || data_o !== STD_PT) begin
      bad++; $display("FAIL post_reset: got cyc=%0d data=%h want %0d %h", cyc, data_o, LATENCY, STD_PT);
    end
    do_ack();
  endtask

  task automatic test_round_trip();
    logic [127:0] pt, ct;
    int cyc;
    for (int n = 0; n < 16; n++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      ct = model_encrypt(pt);
      send(ct, 1'b0);
      wait_result(-1, -1, cyc);
      total++;
      if (cyc != LATENCY || data_o !== pt) begin
        bad++; $display("FAIL round_trip_%0d: got cyc=%0d data=%h want %0d %h", n, cyc, data_o, LATENCY, pt);
      end
      do_ack();
    end
  endtask

  initial begin
    init_model();
    test_reset();
    test_standard();
    test_ack();
    test_busy_reject();
    test_back_to_back();
    test_reset_mid();
    test_round_trip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
